// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multi-cycle LEGv8 sequencer driving the 40-bit datapath control word.
// Define CU_COND_BRANCH_EN to decode B.cond; otherwise B.cond is treated as illegal.
module legv8_control_unit #(
    parameter logic [4:0] FS_AND   = 5'h00,
    parameter logic [4:0] FS_ORR   = 5'h04,
    parameter logic [4:0] FS_ADD   = 5'h08,
    parameter logic [4:0] FS_SUB   = 5'h09,
    parameter logic [4:0] FS_EOR   = 5'h0C,
    parameter logic [4:0] FS_PASSA = 5'h10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  sr_flags,
    output logic [39:0] control_word,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal
);
    typedef enum logic [2:0] {RST = 3'd0, FETCH = 3'd1, EX0 = 3'd2, EX1 = 3'd3, HALT = 3'd7} state_t;

    state_t      r_state;
    logic        r_illegal;
    state_t      w_ns;
    logic [2:0]  w_cgs;
    logic [1:0]  w_ds, w_ps, w_size;
    logic [4:0]  w_fs, w_da, w_sa, w_sb, w_r_fs, w_alu_fs;
    logic        w_as, w_bsel, w_il, w_sl, w_c0, w_mw, w_rw, w_ill;
    logic        w_is_r, w_is_addi, w_is_subi, w_is_imm, w_is_alu, w_is_sub;
    logic        w_is_ldur, w_is_stur, w_is_b, w_is_bl, w_is_cbz, w_is_cbnz, w_is_hlt;
    logic [10:0] w_op;
    logic [4:0]  w_rd, w_rn, w_rm;
    logic        w_unused_imm;

    assign w_op = instruction[31:21];
    assign w_rd = instruction[4:0];
    assign w_rn = instruction[9:5];
    assign w_rm = instruction[20:16];
    // Immediate fields are consumed by the datapath constant generator, not here.
    assign w_unused_imm = ^instruction[15:10];

    always_comb begin
        w_is_r = 1'b1;
        w_r_fs = FS_ADD;
        case (w_op)
            11'h458: w_r_fs = FS_ADD;
            11'h658: w_r_fs = FS_SUB;
            11'h450: w_r_fs = FS_AND;
            11'h550: w_r_fs = FS_ORR;
            11'h650: w_r_fs = FS_EOR;
            default: w_is_r = 1'b0;
        endcase
    end

    assign w_is_addi = w_op[10:1] == 10'h244;
    assign w_is_subi = w_op[10:1] == 10'h344;
    assign w_is_imm  = w_is_addi | w_is_subi;
    assign w_is_alu  = w_is_r | w_is_imm;
    assign w_is_sub  = (w_op == 11'h658) | w_is_subi;
    assign w_alu_fs  = w_is_imm ? (w_is_subi ? FS_SUB : FS_ADD) : w_r_fs;
    assign w_is_ldur = w_op == 11'h7C2;
    assign w_is_stur = w_op == 11'h7C0;
    assign w_is_b    = w_op[10:5] == 6'b000101;
    assign w_is_bl   = w_op[10:5] == 6'b100101;
    assign w_is_cbz  = w_op[10:3] == 8'b10110100;
    assign w_is_cbnz = w_op[10:3] == 8'b10110101;
    assign w_is_hlt  = w_op == 11'h6A2;

`ifdef CU_COND_BRANCH_EN
    logic w_is_bcond, w_cond_base, w_cond_true;
    assign w_is_bcond = w_op[10:3] == 8'b01010100;
    // flags are {V,C,N,Z}; odd condition codes invert the even base test
    always_comb begin
        case (instruction[3:1])
            3'b000:  w_cond_base = sr_flags[0];
            3'b001:  w_cond_base = sr_flags[2];
            3'b010:  w_cond_base = sr_flags[1];
            3'b011:  w_cond_base = sr_flags[3];
            3'b100:  w_cond_base = sr_flags[2] & ~sr_flags[0];
            3'b101:  w_cond_base = sr_flags[1] == sr_flags[3];
            3'b110:  w_cond_base = ~sr_flags[0] & (sr_flags[1] == sr_flags[3]);
            default: w_cond_base = 1'b1;
        endcase
    end
    assign w_cond_true = (instruction[3:1] == 3'b111) | (w_cond_base ^ instruction[0]);
`else
    logic w_unused_flags;
    assign w_unused_flags = ^sr_flags[3:1];
`endif

    always_comb begin
        w_cgs  = 3'b000;
        w_ns   = FETCH;
        w_as   = 1'b0;
        w_ds   = 2'b00;
        w_ps   = 2'b00;
        w_bsel = 1'b0;
        w_il   = 1'b0;
        w_sl   = 1'b0;
        w_fs   = 5'd0;
        w_c0   = 1'b0;
        w_size = 2'b00;
        w_mw   = 1'b0;
        w_rw   = 1'b0;
        w_da   = 5'd0;
        w_sa   = 5'd0;
        w_sb   = 5'd0;
        w_ill  = 1'b0;
        case (r_state)
            FETCH: begin
                w_as   = 1'b1;
                w_ds   = 2'b11;
                w_size = 2'b11;
                w_il   = 1'b1;
                w_ps   = 2'b01;
                w_ns   = EX0;
            end
            EX0: begin
                if (w_is_alu) begin
                    w_sa   = w_rn;
                    w_sb   = w_rm;
                    w_bsel = w_is_imm;
                    w_da   = w_rd;
                    w_rw   = 1'b1;
                    w_fs   = w_alu_fs;
                    w_c0   = w_is_sub;
                    w_sl   = w_is_sub;
                end else if (w_is_ldur | w_is_stur) begin
                    w_sa   = w_rn;
                    w_bsel = 1'b1;
                    w_cgs  = 3'b001;
                    w_fs   = FS_ADD;
                    w_size = 2'b11;
                    w_ds   = w_is_ldur ? 2'b11 : 2'b01;
                    w_rw   = w_is_ldur;
                    w_mw   = w_is_stur;
                    w_da   = w_is_ldur ? w_rd : 5'd0;
                    w_sb   = w_is_stur ? w_rd : 5'd0;
                end else if (w_is_b) begin
                    w_cgs = 3'b010;
                    w_ps  = 2'b10;
                end else if (w_is_bl) begin
                    w_ds = 2'b10;
                    w_rw = 1'b1;
                    w_da = 5'd30;
                    w_ns = EX1;
                end else if (w_is_cbz | w_is_cbnz) begin
                    w_sa = w_rd;
                    w_fs = FS_PASSA;
                    w_sl = 1'b1;
                    w_ns = EX1;
`ifdef CU_COND_BRANCH_EN
                end else if (w_is_bcond) begin
                    w_cgs = 3'b011;
                    w_ps  = w_cond_true ? 2'b10 : 2'b00;
`endif
                end else if (w_is_hlt) begin
                    w_ns = HALT;
                end else begin
                    w_ill = 1'b1;
                    w_ns  = HALT;
                end
            end
            EX1: begin
                // Z here was loaded by the PASSA in EX0
                if (w_is_bl) begin
                    w_cgs = 3'b010;
                    w_ps  = 2'b10;
                end else if ((w_is_cbz & sr_flags[0]) | (w_is_cbnz & ~sr_flags[0])) begin
                    w_cgs = 3'b011;
                    w_ps  = 2'b10;
                end
            end
            HALT:    w_ns = HALT;
            default: w_ns = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= RST;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_ns;
            r_illegal <= r_illegal | w_ill;
        end
    end

    assign control_word = {w_cgs, w_ns, w_as, w_ds, w_ps, 1'b0, w_bsel, w_il, w_sl,
                           w_fs, w_c0, w_size, w_mw, w_rw, w_da, w_sa, w_sb};
    assign state   = r_state;
    assign halted  = r_state == HALT;
    assign illegal = r_illegal;
endmodule

// File: tb/tb_legv8_control_unit.sv
// tb_legv8_control_unit: directed checks of the LEGv8 control unit state sequence and control words.
module tb_legv8_control_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [3:0]  sr_flags = 4'd0;
    logic [39:0] control_word;
    logic [2:0]  state;
    logic        halted, illegal;
    int          n_tests = 0;
    int          n_fail = 0;

    legv8_control_unit dut (
        .clock(clock), .reset(reset), .instruction(instruction), .sr_flags(sr_flags),
        .control_word(control_word), .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [39:0] cw(input logic [2:0] cgs, input logic [2:0] ns, input logic as_,
        input logic [1:0] ds, input logic [1:0] ps, input logic bsel, input logic il, input logic sl,
        input logic [4:0] fs, input logic c0, input logic [1:0] sz, input logic mw, input logic rw,
        input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
        return {cgs, ns, as_, ds, ps, 1'b0, bsel, il, sl, fs, c0, sz, mw, rw, da, sa, sb};
    endfunction

    task automatic do_reset(input logic [31:0] ins);
        instruction = ins;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic to_ex0(input logic [31:0] ins);
        do_reset(ins);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_tests++; if (control_word !== cw(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL reset_word: got %h expected %h", control_word, cw(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0)); end
        n_tests++; if ({halted, illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {halted, illegal}); end
    endtask

    task automatic test_illegal_zero;
        logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd7, 3'd7};
        do_reset(32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_tests++; if (state !== exp_st[i]) begin n_fail++; $display("FAIL zero_state%0d: got %0d expected %0d", i, state, exp_st[i]); end
            n_tests++; if (control_word[16:15] !== 2'b00) begin n_fail++; $display("FAIL zero_mwrw%0d: got %b expected 00", i, control_word[16:15]); end
            if (i == 1) begin
                n_tests++; if (control_word !== cw(0,7,0,0,0,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL zero_ex0_word: got %h", control_word); end
            end
        end
        n_tests++; if ({halted, illegal} !== 2'b11) begin n_fail++; $display("FAIL zero_halt_illegal: got %b expected 11", {halted, illegal}); end
        reset = 1'b0;
        #1;
        n_tests++; if ({state, illegal, halted} !== 5'b00000) begin n_fail++; $display("FAIL reset_clears: got %b expected 00000", {state, illegal, halted}); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_alu;
        logic [31:0] ins [7] = '{32'h8B020023, 32'hCB020023, 32'h8A020023, 32'hAA020023, 32'hCA020023, 32'h91001441, 32'hD1001441};
        logic [39:0] exp [7];
        exp[0] = cw(0,1,0,0,0,0,0,0,5'h08,0,0,0,1,3,1,2);
        exp[1] = cw(0,1,0,0,0,0,0,1,5'h09,1,0,0,1,3,1,2);
        exp[2] = cw(0,1,0,0,0,0,0,0,5'h00,0,0,0,1,3,1,2);
        exp[3] = cw(0,1,0,0,0,0,0,0,5'h04,0,0,0,1,3,1,2);
        exp[4] = cw(0,1,0,0,0,0,0,0,5'h0C,0,0,0,1,3,1,2);
        exp[5] = cw(0,1,0,0,0,1,0,0,5'h08,0,0,0,1,1,2,0);
        exp[6] = cw(0,1,0,0,0,1,0,1,5'h09,1,0,0,1,1,2,0);
        for (int i = 0; i < 7; i++) begin
            to_ex0(ins[i]);
            n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL alu%0d_state: got %0d expected 2", i, state); end
            n_tests++; if (control_word !== exp[i]) begin n_fail++; $display("FAIL alu%0d_word: got %h expected %h", i, control_word, exp[i]); end
        end
        to_ex0(32'h8B020023);
        @(negedge clock);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL add_next_state: got %0d expected 1", state); end
        n_tests++; if (control_word !== cw(0,2,1,3,1,0,1,0,0,0,3,0,0,0,0,0)) begin n_fail++; $display("FAIL fetch_word: got %h expected %h", control_word, cw(0,2,1,3,1,0,1,0,0,0,3,0,0,0,0,0)); end
    endtask

    task automatic test_mem;
        to_ex0(32'hF8410067);
        n_tests++; if (control_word !== cw(1,1,0,3,0,1,0,0,5'h08,0,3,0,1,7,3,0)) begin n_fail++; $display("FAIL ldur_word: got %h expected %h", control_word, cw(1,1,0,3,0,1,0,0,5'h08,0,3,0,1,7,3,0)); end
        to_ex0(32'hF8008045);
        n_tests++; if ({control_word[39:31], control_word[27], control_word[24:20], control_word[16:15], control_word[9:0]} !== {3'b001, 3'd1, 1'b0, 2'b01, 1'b1, 5'h08, 2'b10, 5'd2, 5'd5})
            begin n_fail++; $display("FAIL stur_fields: got word %h", control_word); end
    endtask

    task automatic test_branch;
        to_ex0(32'h14000003);
        n_tests++; if (control_word !== cw(2,1,0,0,2,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL b_word: got %h", control_word); end
        @(negedge clock);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL b_cycles: got %0d expected 1", state); end
        to_ex0(32'h94000002);
        n_tests++; if (control_word !== cw(0,3,0,2,0,0,0,0,0,0,0,0,1,30,0,0)) begin n_fail++; $display("FAIL bl_ex0_word: got %h", control_word); end
        @(negedge clock);
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL bl_ex1_state: got %0d expected 3", state); end
        n_tests++; if (control_word !== cw(2,1,0,0,2,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL bl_ex1_word: got %h", control_word); end
        @(negedge clock);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL bl_cycles: got %0d expected 1", state); end
    endtask

    task automatic test_cbz;
        logic [31:0] ins [4] = '{32'hB4000004, 32'hB4000004, 32'hB5000004, 32'hB5000004};
        logic [3:0]  flg [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
        logic        tkn [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            sr_flags = 4'b0000;
            to_ex0(ins[i]);
            n_tests++; if (control_word !== cw(0,3,0,0,0,0,0,1,5'h10,0,0,0,0,0,4,0)) begin n_fail++; $display("FAIL cb%0d_ex0_word: got %h", i, control_word); end
            sr_flags = flg[i];
            @(negedge clock);
            n_tests++; if (control_word !== (tkn[i] ? cw(3,1,0,0,2,0,0,0,0,0,0,0,0,0,0,0) : cw(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0)))
                begin n_fail++; $display("FAIL cb%0d_ex1_word: got %h taken %b", i, control_word, tkn[i]); end
        end
        sr_flags = 4'b0000;
    endtask

    task automatic test_bcond;
`ifdef CU_COND_BRANCH_EN
        logic [3:0] cnd [10] = '{4'hC, 4'hC, 4'h0, 4'h1, 4'hB, 4'hA, 4'h8, 4'h9, 4'hE, 4'h6};
        logic [3:0] flg [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1010, 4'b0100, 4'b0100, 4'b0001, 4'b1000};
        logic       tkn [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            sr_flags = flg[i];
            to_ex0({28'h5400000, cnd[i]});
            n_tests++; if (control_word !== cw(3,1,0,0,tkn[i] ? 2'b10 : 2'b00,0,0,0,0,0,0,0,0,0,0,0))
                begin n_fail++; $display("FAIL bcond%0d_word: got %h taken %b", i, control_word, tkn[i]); end
        end
        sr_flags = 4'b0000;
`else
        to_ex0(32'h5400000C);
        n_tests++; if (control_word !== cw(0,7,0,0,0,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL bcond_off_word: got %h", control_word); end
        @(negedge clock);
        n_tests++; if ({state, illegal} !== {3'd7, 1'b1}) begin n_fail++; $display("FAIL bcond_off_halt: got %b expected 1111", {state, illegal}); end
`endif
    endtask

    task automatic test_hlt;
        to_ex0(32'hD4400000);
        n_tests++; if (control_word !== cw(0,7,0,0,0,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL hlt_word: got %h", control_word); end
        repeat (3) @(negedge clock);
        n_tests++; if ({state, halted, illegal} !== {3'd7, 1'b1, 1'b0}) begin n_fail++; $display("FAIL hlt_stay: got %b expected 11110", {state, halted, illegal}); end
    endtask

    task automatic test_reset_mid_ex0;
        to_ex0(32'h8B020023);
        #2 reset = 1'b0;
        #1;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL abort_state: got %0d expected 0", state); end
        n_tests++; if (control_word !== cw(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL abort_word: got %h", control_word); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        reset = 1'b1;
        test_illegal_zero();
        test_alu();
        test_mem();
        test_branch();
        test_cbz();
        test_bcond();
        test_hlt();
        test_reset_mid_ex0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
